// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM and ALU decoder for the multicycle RV32I core (lw, sw, R/I ALU, beq, jal).
// Memory states honour a mem_ready handshake; all outputs are decoded from the registered state.
//
//   state    | meaning
//   FETCH    | read instruction at PC, PC <= PC+4 when memory accepts
//   DECODE   | read registers, precompute OldPC+imm
//   MEMADR   | rs1 + imm address for lw/sw
//   MEMREAD  | load access, held until mem_ready
//   MEMWB    | write loaded data to rd
//   MEMWRITE | store strobe, held until mem_ready
//   EXECR    | R-type ALU operation
//   EXECI    | I-type ALU operation
//   ALUWB    | write ALU result to rd
//   BEQ      | compare rs1/rs2, branch on zero
//   JAL      | PC <= target, ALU forms return address
//   HALT     | stopped after illegal opcode, exits on reset only
module riscv_multicycle_ctrl #(
  parameter bit HANDSHAKE    = 1'b1,
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       adr_src_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] imm_src_o,
  output logic       reg_write_o,
  output logic [2:0] alu_ctrl_o,
  output logic       illegal_o,
  output logic       halted_o
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_HALT
  } state_t;

  state_t state_q, state_d;
  logic   rdy;

  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_ok);
    logic [2:0] r;
    r = ALU_ADD;
    case (f3)
      3'b000:  r = sub_ok ? ALU_SUB : ALU_ADD;
      3'b010:  r = ALU_SLT;
      3'b110:  r = ALU_OR;
      3'b111:  r = ALU_AND;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!reset_i) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    rdy          = HANDSHAKE ? mem_ready_i : 1'b1;
    pc_write_o   = 1'b0;
    adr_src_o    = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    result_src_o = 2'b00;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    reg_write_o  = 1'b0;
    alu_ctrl_o   = ALU_ADD;
    illegal_o    = 1'b0;
    halted_o     = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        ir_write_o   = rdy;
        pc_write_o   = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        case (op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            illegal_o = 1'b1;
            state_d   = ILLEGAL_HALT ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        state_d     = (op_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src_o = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_o = 2'b01;
        reg_write_o  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_o   = 1'b1;
        mem_write_o = 1'b1;
        if (rdy) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a_o = 2'b10;
        alu_ctrl_o  = alu_decode(funct3_i, funct7b5_i);
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_ctrl_o  = alu_decode(funct3_i, 1'b0);
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_o = 2'b10;
        alu_ctrl_o  = ALU_SUB;
        pc_write_o  = zero_i;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_write_o  = 1'b1;
        state_d     = S_ALUWB;
      end
      S_HALT: halted_o = 1'b1;
      default: state_d = S_FETCH;
    endcase
    // Reset held low must never let an in-flight access or write escape.
    if (!reset_i) begin
      pc_write_o  = 1'b0;
      ir_write_o  = 1'b0;
      mem_write_o = 1'b0;
      reg_write_o = 1'b0;
    end
  end

  always_comb begin
    imm_src_o = 2'b00;
    case (op_i)
      OP_SW:   imm_src_o = 2'b01;
      OP_BEQ:  imm_src_o = 2'b10;
      OP_JAL:  imm_src_o = 2'b11;
      default: imm_src_o = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Randomized instruction stream checked cycle by cycle against a per-instruction phase model,
// plus directed illegal/halt, no-handshake and reset-during-store scenarios.
module tb_riscv_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] op = 7'b0000011;
  logic [2:0] f3 = 3'b000;
  logic       f7 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic [17:0] out_m, out_h, out_n;
  localparam logic [17:0] EN_MASK = 18'b10_1100_0000_0010_0000;

  always #5 clk = ~clk;

  logic       pcw_m, adr_m, mw_m, irw_m, rw_m, ill_m, hlt_m;
  logic [1:0] rs_m, sa_m, sb_m, imm_m;
  logic [2:0] alu_m;
  logic       pcw_h, adr_h, mw_h, irw_h, rw_h, ill_h, hlt_h;
  logic [1:0] rs_h, sa_h, sb_h, imm_h;
  logic [2:0] alu_h;
  logic       pcw_n, adr_n, mw_n, irw_n, rw_n, ill_n, hlt_n;
  logic [1:0] rs_n, sa_n, sb_n, imm_n;
  logic [2:0] alu_n;

  riscv_multicycle_ctrl #(.HANDSHAKE(1'b1), .ILLEGAL_HALT(1'b0)) u_dut (
    .clk_i(clk), .reset_i(reset), .op_i(op), .funct3_i(f3), .funct7b5_i(f7),
    .zero_i(zero), .mem_ready_i(mem_ready),
    .pc_write_o(pcw_m), .adr_src_o(adr_m), .mem_write_o(mw_m), .ir_write_o(irw_m),
    .result_src_o(rs_m), .alu_src_a_o(sa_m), .alu_src_b_o(sb_m), .imm_src_o(imm_m),
    .reg_write_o(rw_m), .alu_ctrl_o(alu_m), .illegal_o(ill_m), .halted_o(hlt_m));

  riscv_multicycle_ctrl #(.HANDSHAKE(1'b1), .ILLEGAL_HALT(1'b1)) u_halt (
    .clk_i(clk), .reset_i(reset), .op_i(op), .funct3_i(f3), .funct7b5_i(f7),
    .zero_i(zero), .mem_ready_i(mem_ready),
    .pc_write_o(pcw_h), .adr_src_o(adr_h), .mem_write_o(mw_h), .ir_write_o(irw_h),
    .result_src_o(rs_h), .alu_src_a_o(sa_h), .alu_src_b_o(sb_h), .imm_src_o(imm_h),
    .reg_write_o(rw_h), .alu_ctrl_o(alu_h), .illegal_o(ill_h), .halted_o(hlt_h));

  riscv_multicycle_ctrl #(.HANDSHAKE(1'b0), .ILLEGAL_HALT(1'b0)) u_nohs (
    .clk_i(clk), .reset_i(reset), .op_i(op), .funct3_i(f3), .funct7b5_i(f7),
    .zero_i(zero), .mem_ready_i(mem_ready),
    .pc_write_o(pcw_n), .adr_src_o(adr_n), .mem_write_o(mw_n), .ir_write_o(irw_n),
    .result_src_o(rs_n), .alu_src_a_o(sa_n), .alu_src_b_o(sb_n), .imm_src_o(imm_n),
    .reg_write_o(rw_n), .alu_ctrl_o(alu_n), .illegal_o(ill_n), .halted_o(hlt_n));

  assign out_m = {pcw_m, adr_m, mw_m, irw_m, rs_m, sa_m, sb_m, imm_m, rw_m, alu_m, ill_m, hlt_m};
  assign out_h = {pcw_h, adr_h, mw_h, irw_h, rs_h, sa_h, sb_h, imm_h, rw_h, alu_h, ill_h, hlt_h};
  assign out_n = {pcw_n, adr_n, mw_n, irw_n, rs_n, sa_n, sb_n, imm_n, rw_n, alu_n, ill_n, hlt_n};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef enum int {K_LW, K_SW, K_R, K_I, K_BEQ, K_JAL, K_ILL} kind_t;

  typedef struct {
    string       tag;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        mr;
    logic        z;
    logic [17:0] exp;
  } cyc_t;

  cyc_t q[$];
  logic [6:0] c_op;
  logic [2:0] c_f3;
  logic       c_f7;

  function automatic logic [17:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] imm, input logic rw,
                                     input logic [2:0] alu, input logic ill, input logic hlt);
    return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, alu, ill, hlt};
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  // add=0 sub=1 and=2 or=3 slt=5, chosen by funct3 meaning
  function automatic logic [2:0] alu_of(input kind_t k, input logic [2:0] fn3, input logic fn7);
    if (fn3 == 3'd0) return (k == K_R && fn7) ? 3'd1 : 3'd0;
    if (fn3 == 3'd2) return 3'd5;
    if (fn3 == 3'd6) return 3'd3;
    if (fn3 == 3'd7) return 3'd2;
    return 3'd0;
  endfunction

  task automatic add(input string tag, input logic mr, input logic z, input logic [17:0] exp);
    cyc_t c;
    c.tag = tag; c.op = c_op; c.f3 = c_f3; c.f7 = c_f7; c.mr = mr; c.z = z; c.exp = exp;
    q.push_back(c);
  endtask

  task automatic gen_instr(input kind_t k, input logic [2:0] fn3, input logic fn7,
                           input int fstall, input int mstall);
    logic [1:0] im;
    logic       z;
    case (k)
      K_LW:    c_op = 7'b0000011;
      K_SW:    c_op = 7'b0100011;
      K_R:     c_op = 7'b0110011;
      K_I:     c_op = 7'b0010011;
      K_BEQ:   c_op = 7'b1100011;
      K_JAL:   c_op = 7'b1101111;
      default: c_op = ($urandom_range(0, 1) == 0) ? 7'b1111111 : 7'b0000000;
    endcase
    c_f3 = fn3; c_f7 = fn7;
    im = imm_of(c_op);
    for (int i = 0; i < fstall; i++)
      add("fetch_stall", 1'b0, 1'($urandom), mk(0, 0, 0, 0, 2, 0, 2, im, 0, 0, 0, 0));
    add("fetch", 1'b1, 1'($urandom), mk(1, 0, 0, 1, 2, 0, 2, im, 0, 0, 0, 0));
    add("decode", 1'($urandom), 1'($urandom),
        mk(0, 0, 0, 0, 0, 1, 1, im, 0, 0, (k == K_ILL), 0));
    case (k)
      K_LW: begin
        add("memadr", 1'($urandom), 1'($urandom), mk(0, 0, 0, 0, 0, 2, 1, im, 0, 0, 0, 0));
        for (int i = 0; i < mstall; i++)
          add("memread_stall", 1'b0, 1'($urandom), mk(0, 1, 0, 0, 0, 0, 0, im, 0, 0, 0, 0));
        add("memread", 1'b1, 1'($urandom), mk(0, 1, 0, 0, 0, 0, 0, im, 0, 0, 0, 0));
        add("memwb", 1'($urandom), 1'($urandom), mk(0, 0, 0, 0, 1, 0, 0, im, 1, 0, 0, 0));
      end
      K_SW: begin
        add("memadr", 1'($urandom), 1'($urandom), mk(0, 0, 0, 0, 0, 2, 1, im, 0, 0, 0, 0));
        for (int i = 0; i < mstall; i++)
          add("memwrite_stall", 1'b0, 1'($urandom), mk(0, 1, 1, 0, 0, 0, 0, im, 0, 0, 0, 0));
        add("memwrite", 1'b1, 1'($urandom), mk(0, 1, 1, 0, 0, 0, 0, im, 0, 0, 0, 0));
      end
      K_R, K_I: begin
        add("exec", 1'($urandom), 1'($urandom),
            mk(0, 0, 0, 0, 0, 2, (k == K_I) ? 2'd1 : 2'd0, im, 0, alu_of(k, fn3, fn7), 0, 0));
        add("aluwb", 1'($urandom), 1'($urandom), mk(0, 0, 0, 0, 0, 0, 0, im, 1, 0, 0, 0));
      end
      K_BEQ: begin
        z = 1'($urandom);
        add("beq", 1'($urandom), z, mk(z, 0, 0, 0, 0, 2, 0, im, 0, 3'd1, 0, 0));
      end
      K_JAL: begin
        add("jal", 1'($urandom), 1'($urandom), mk(1, 0, 0, 0, 0, 1, 2, im, 0, 0, 0, 0));
        add("aluwb", 1'($urandom), 1'($urandom), mk(0, 0, 0, 0, 0, 0, 0, im, 1, 0, 0, 0));
      end
      default: ;
    endcase
  endtask

  // Called at posedge+1: drive, check at +2, then advance to next posedge+1.
  task automatic step(input cyc_t c);
    op = c.op; f3 = c.f3; f7 = c.f7; mem_ready = c.mr; zero = c.z;
    #1 check_eq(c.tag, 32'(out_m), 32'(c.exp));
    @(posedge clk); #1;
  endtask

  task automatic run_queue();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      step(c);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    do_reset();

    // Illegal opcode: main instance skips, halting instance parks in HALT.
    op = 7'b1111111; f3 = 3'd0; f7 = 1'b0; mem_ready = 1'b1;
    #1 check_eq("reset_fetch", 32'(out_m), 32'(mk(1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0, 0)));
    @(posedge clk); #2;
    check_eq("ill_pulse_m", 32'(out_m[1]), 32'd1);
    check_eq("ill_pulse_h", 32'(out_h[1]), 32'd1);
    @(posedge clk); #2;
    check_eq("ill_skip_fetch", 32'(out_m), 32'(mk(1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0, 0)));
    for (int i = 0; i < 3; i++) begin
      check_eq("halt_state", 32'(out_h), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
      @(posedge clk); #2;
    end
    reset = 1'b0;
    #1 check_eq("reset_en_off", 32'(out_h & EN_MASK), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1 check_eq("halt_exit", 32'(out_h), 32'(mk(1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0, 0)));

    // No handshake: lw completes in 5 cycles with mem_ready stuck low.
    do_reset();
    op = 7'b0000011; f3 = 3'd2; mem_ready = 1'b0;
    #1 check_eq("nohs_fetch", 32'(out_n), 32'(mk(1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0, 0)));
    @(posedge clk); #2;
    check_eq("nohs_decode", 32'(out_n), 32'(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0)));
    @(posedge clk); #2;
    check_eq("nohs_memadr", 32'(out_n), 32'(mk(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0)));
    @(posedge clk); #2;
    check_eq("nohs_memread", 32'(out_n), 32'(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    @(posedge clk); #2;
    check_eq("nohs_memwb", 32'(out_n), 32'(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0)));
    @(posedge clk); #2;
    check_eq("nohs_refetch", 32'(out_n), 32'(mk(1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0, 0)));

    // Directed then random instruction stream on the handshaking instance.
    do_reset();
    gen_instr(K_LW, 3'd2, 1'b0, 0, 0);
    gen_instr(K_SW, 3'd2, 1'b0, 1, 3);
    gen_instr(K_R, 3'd0, 1'b1, 0, 0);
    gen_instr(K_I, 3'd0, 1'b1, 0, 0);
    gen_instr(K_BEQ, 3'd0, 1'b0, 0, 0);
    gen_instr(K_JAL, 3'd0, 1'b0, 2, 0);
    gen_instr(K_ILL, 3'd0, 1'b0, 0, 0);
    run_queue();
    for (int n = 0; n < 80; n++) begin
      gen_instr(kind_t'($urandom_range(0, 6)), 3'($urandom), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 3));
      run_queue();
    end

    // Reset while a store is stalled: no write may escape, back to FETCH.
    c_op = 7'b0100011; c_f3 = 3'd2; c_f7 = 1'b0;
    add("sw_fetch", 1'b1, 1'b0, mk(1, 0, 0, 1, 2, 0, 2, 1, 0, 0, 0, 0));
    add("sw_decode", 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    add("sw_memadr", 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0));
    add("sw_stall", 1'b0, 1'b0, mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    run_queue();
    reset = 1'b0; mem_ready = 1'b1;
    #1 check_eq("rst_abort_write", 32'(out_m & EN_MASK), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1; mem_ready = 1'b0;
    #1 check_eq("rst_abort_fetch", 32'(out_m), 32'(mk(0, 0, 0, 0, 2, 0, 2, 1, 0, 0, 0, 0)));
    @(posedge clk); #2;
    check_eq("rst_abort_hold", 32'(out_m), 32'(mk(0, 0, 0, 0, 2, 0, 2, 1, 0, 0, 0, 0)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
